index_stream_buffer: RTL and testbench
======================================

# index_stream_buffer

Parametrised index buffer for the sparse-matrix datapath. It accepts packed words of column indices from the memory slot, holds up to DEPTH words in a registered ring store, and serialises them to the multiply pipeline one index per cycle under a valid/ready handshake. It supports partial (tail) words, a frame-end marker and occupancy reporting. It replaces the fixed 4×16-bit bram/control pair with a configurable width, lane count and depth.

## Interface
- IDX_W, 16, bits per index
- LANES, 4, indices packed per input word (≥1)
- DEPTH, 4, words of storage (power of two, ≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  buffer can accept a word this cycle
- in_word  in  IDX_W*LANES  packed indices, lane 0 in bits [IDX_W-1:0]
- in_count  in  $clog2(LANES+1)  number of valid lanes, 1..LANES, lanes 0..in_count-1 are used
- in_last  in  1  word ends a matrix row/frame
- out_valid  out  1  out_index is valid
- out_ready  in  1  consumer takes out_index this cycle
- out_index  out  IDX_W  current index
- out_last  out  1  final index of a word tagged in_last
- level  out  $clog2(DEPTH+1)  words currently stored, including a partially drained word
- err  out  1  sticky: a word arrived with in_count==0 or in_count>LANES

## Operation
- Storage: DEPTH entries of {word, count, last}; write pointer wp, read pointer rp, lane counter ln, level counter.
- Write: on edge with in_valid && in_ready, store entry at wp, wp←wp+1 mod DEPTH.
- Illegal in_count (0 or >LANES): word is accepted (handshake completes), not stored, err←1. err clears only on reset.
- Read: out_valid = (level≠0); out_index = lane ln of entry rp; out_last = entry.last && ln==entry.count−1.
- On edge with out_valid && out_ready: if ln==entry.count−1, set ln←0 and rp←rp+1 mod DEPTH (word retired); otherwise ln←ln+1.
- level: +1 on a stored write, −1 on a retire, unchanged when both occur in the same edge.
- in_ready = (level≠DEPTH); it does not depend on same-cycle retirement (no pass-through when full).
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally; full and empty are distinguished by level, not pointer equality.

## Timing
- Reset (asynchronous, while low): wp=rp=ln=0, level=0, err=0, so out_valid=0, in_ready=1, out_last=0. Stored data is don't-care and is not cleared.
- Reset asserted mid-stream discards all entries. The first accepted word after release is the next one output.
- Latency: a word written at edge k has its lane 0 on out_index in the cycle after edge k, when the buffer was empty.
- Throughput: one index per cycle while out_ready=1. An input word of count c occupies its slot for c output handshakes.
- out_index, out_valid and out_last are combinational from registered state only, with no path from out_ready. in_ready has no path from in_valid.
- out_valid is held while out_ready=0. out_index and out_last stay stable until the handshake.
- Simultaneous write and retire at level==DEPTH is impossible (in_ready=0). At level==DEPTH−1 both proceed and level stays at DEPTH−1.

## Test plan
- Reset then a single word 0x0004_0003_0002_0001, count=4, last=1, out_ready=1 → out_index 1,2,3,4 on consecutive cycles starting 1 cycle after write; out_last only on 4; level returns to 0.
- Tail word count=2, data 0x…_00BB_00AA, last=1 → outputs 0xAA then 0xBB (out_last=1); lanes 2..3 are never emitted.
- Fill with DEPTH words while out_ready=0 → level=DEPTH, in_ready=0, and a 5th presented word is not accepted. Release out_ready → in_ready rises after the first word retires; all 4*DEPTH indices emerge in order across pointer wrap.
- Back-pressure: toggle out_ready every other cycle with continuous input → no index dropped or duplicated; out_index stable during stalls.
- in_count=0 with in_valid → handshake completes, err=1, level unchanged, no output. err stays 1 until reset.
- Assert reset low for 1 cycle mid-word (ln=2) → out_valid=0 immediately, level=0. The next written word starts at lane 0.

Source files
------------

// File: rtl/index_stream_buffer.sv
// Ring buffer of packed index words, serialised one index per cycle.
// Partial words, a frame-end marker, occupancy and a sticky error flag for illegal lane counts.
module index_stream_buffer #(
  parameter int IDX_W = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [IDX_W*LANES-1:0]       in_word_i,
  input  logic [$clog2(LANES+1)-1:0]   in_count_i,
  input  logic                         in_last_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [IDX_W-1:0]             out_index_o,
  output logic                         out_last_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         err_o
);

  localparam int CW = $clog2(LANES + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [IDX_W*LANES-1:0] word_q [DEPTH];
  logic [CW-1:0]          cnt_q  [DEPTH];
  logic                   last_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] ln_q, ln_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;

  logic          illegal, wr_fire, store, rd_fire, at_end, retire;
  logic [CW-1:0] end_ln;

  assign illegal = (in_count_i == '0) || (in_count_i > CW'(LANES));
  assign wr_fire = in_valid_i && in_ready_o;
  assign store   = wr_fire && !illegal;
  assign rd_fire = out_valid_o && out_ready_i;
  assign end_ln  = cnt_q[rp_q] - CW'(1);
  assign at_end  = (ln_q == end_ln);
  assign retire  = rd_fire && at_end;

  // Outputs depend on registered state only; full/empty come from the level counter.
  assign out_valid_o = (level_q != '0);
  assign in_ready_o  = (level_q != LW'(DEPTH));
  assign out_last_o  = out_valid_o && last_q[rp_q] && at_end;
  assign level_o     = level_q;
  assign err_o       = err_q;

  always_comb begin
    out_index_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ln_q == CW'(i)) out_index_o = word_q[rp_q][i*IDX_W +: IDX_W];
    end
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    ln_d    = ln_q;
    level_d = level_q;
    err_d   = err_q;
    if (store) wp_d = wp_q + PW'(1);
    if (wr_fire && illegal) err_d = 1'b1;
    if (rd_fire) begin
      if (at_end) begin
        ln_d = '0;
        rp_d = rp_q + PW'(1);
      end else begin
        ln_d = ln_q + CW'(1);
      end
    end
    if (store && !retire) level_d = level_q + LW'(1);
    else if (!store && retire) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q    <= '0;
      rp_q    <= '0;
      ln_q    <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ln_q    <= ln_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Payload storage is not reset; level gates whether it is ever observed.
  always_ff @(posedge clk_i) begin
    if (store) begin
      word_q[wp_q] <= in_word_i;
      cnt_q[wp_q]  <= in_count_i;
      last_q[wp_q] <= in_last_i;
    end
  end

endmodule

// File: tb/tb_index_stream_buffer.sv
// Directed and randomised bench for index_stream_buffer against a queue-of-indices model.
module tb_index_stream_buffer;
  localparam int IDX_W = 16;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(LANES + 1);
  localparam int LW = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid, in_ready, in_last;
  logic [IDX_W*LANES-1:0] in_word;
  logic [CW-1:0]          in_count;
  logic                   out_valid, out_ready, out_last;
  logic [IDX_W-1:0]       out_index;
  logic [LW-1:0]          level;
  logic                   err;

  index_stream_buffer #(.IDX_W(IDX_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_word_i(in_word),
    .in_count_i(in_count), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_index_o(out_index),
    .out_last_o(out_last), .level_o(level), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             wend;
  } ent_t;

  ent_t q[$];
  logic err_m;
  int   errs = 0;
  int   checks = 0;
  logic [IDX_W-1:0] prev_idx;
  logic             prev_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int words_m();
    int n = 0;
    foreach (q[i]) if (q[i].wend) n++;
    return n;
  endfunction

  // One clock: compare outputs against the model at negedge, then apply the handshakes to the model.
  task automatic cycle();
    int  lv;
    bit  acc, rd;
    ent_t e;
    @(negedge clk);
    lv = words_m();
    chk("out_valid", out_valid, q.size() != 0);
    chk("level", level, lv);
    chk("in_ready", in_ready, lv != DEPTH);
    chk("err", err, err_m);
    if (q.size() != 0) begin
      chk("out_index", out_index, q[0].idx);
      chk("out_last", out_last, q[0].last);
    end
    if (prev_stall) chk("stall_stable", out_index, prev_idx);
    acc = in_valid && (lv != DEPTH);
    rd  = (q.size() != 0) && out_ready;
    prev_stall = (q.size() != 0) && !out_ready;
    prev_idx   = out_index;
    if (rd) void'(q.pop_front());
    if (acc) begin
      if (in_count == 0 || in_count > LANES) err_m = 1'b1;
      else begin
        for (int i = 0; i < in_count; i++) begin
          e.idx  = in_word[i*IDX_W +: IDX_W];
          e.wend = (i == in_count - 1);
          e.last = e.wend && in_last;
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [63:0] w, input int c, input logic l);
    in_valid = 1'b1;
    in_word  = w;
    in_count = CW'(c);
    in_last  = l;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    cycle();
    chk("drained_level", level, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_count = '0; in_last = 1'b0;
    out_ready = 1'b0; err_m = 1'b0; prev_stall = 1'b0; prev_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_level", level, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single full word, consumer always ready.
    out_ready = 1'b1;
    put(64'h0004_0003_0002_0001, 4, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("lat_lane0", out_index, 16'h0001);
    drain(20);

    // Tail word with junk in unused lanes.
    put(64'hDEAD_BEEF_00BB_00AA, 2, 1'b1);
    cycle();
    in_valid = 1'b0;
    drain(20);

    // Fill while stalled; the extra word waits until a slot frees.
    out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      put({16'(k*4+4), 16'(k*4+3), 16'(k*4+2), 16'(k*4+1)}, 4, k[0]);
      if (k == DEPTH) begin
        chk("full_level", level, DEPTH);
        chk("full_in_ready", in_ready, 0);
      end
      cycle();
    end
    cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    drain(40);

    // Alternating back-pressure with continuous input.
    for (int k = 0; k < 24; k++) begin
      put({$urandom(), $urandom()}, $urandom_range(1, LANES), $urandom_range(0, 1));
      out_ready = k[0];
      cycle();
    end
    drain(120);

    // Illegal lane count: accepted, not stored, sticky error.
    put(64'h1111_2222_3333_4444, 0, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("err_set", err, 1);
    chk("err_level", level, 0);
    repeat (3) cycle();
    chk("err_sticky", err, 1);

    // Reset mid-word at lane 2.
    out_ready = 1'b0;
    put(64'h0044_0033_0022_0011, 4, 1'b0);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("mid_lane2", out_index, 16'h0033);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_err", err, 0);
    q.delete();
    err_m = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    put(64'h00D4_00D3_00D2_00D1, 4, 1'b1);
    cycle();
    in_valid = 1'b0;
    chk("post_rst_lane0", out_index, 16'h00D1);
    drain(20);

    // Random traffic with occasional illegal counts.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_word   = {$urandom(), $urandom()};
      in_count  = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(0, 7)) : CW'($urandom_range(1, LANES));
      in_last   = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain(200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
